// File: rtl/ldm_stm_pkg.sv
// rtl/ldm_stm_pkg.sv - shared types and constants for the LDM/STM sequencer
package ldm_stm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Addressing mode packed as {P, U}
  typedef logic [1:0] addr_mode_t;

  localparam addr_mode_t MODE_DA = 2'b00;
  localparam addr_mode_t MODE_IA = 2'b01;
  localparam addr_mode_t MODE_DB = 2'b10;
  localparam addr_mode_t MODE_IB = 2'b11;

  localparam int REG_COUNT = 16;
  localparam int PC_INDEX  = 15;

  function automatic logic [4:0] popcount16(input logic [REG_COUNT-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < REG_COUNT; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// rtl/lowest_set_bit_encoder.sv - index of the lowest set bit in a 16-bit register list
module lowest_set_bit_encoder
  import ldm_stm_pkg::*;
(
  input  logic [REG_COUNT-1:0] i_vec,
  output logic [3:0]           o_idx,
  output logic                 o_valid
);

  // Scan downwards so the lowest set bit is the last one to assign.
  always_comb begin
    o_idx   = 4'd0;
    o_valid = 1'b0;
    for (int i = PC_INDEX; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = i[3:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - ARMv4 LDM/STM block-transfer sequencer (optional LDM_STM_ABORT_EN)
module ldm_stm_sequencer
  import ldm_stm_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        IS_LOAD,
  input  logic        P_BIT,
  input  logic        U_BIT,
  input  logic        W_BIT,
  input  logic [3:0]  ADDRS_RN,
  input  logic [31:0] RN_DATA,
  input  logic [15:0] REG_LIST,
  input  logic [31:0] RM_DATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_READY,
`ifdef LDM_STM_ABORT_EN
  input  logic        MEM_ABORT,
  output logic        ABORTED,
`endif
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  ADDRS_RM,
  output logic [3:0]  ADDRS_RD,
  output logic [31:0] WRT_DATA,
  output logic        WRT_ENA,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [31:0] LP_STEP = 32'(WORD_BYTES);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_list;
  logic [31:0]   r_addr;
  logic [31:0]   r_new_base;
  logic [3:0]    r_rn;
  logic          r_load;
  logic          r_w;
  logic          r_rn_in_list;

  logic [4:0]    w_n;
  logic [31:0]   w_span;
  addr_mode_t    w_mode;
  logic [31:0]   w_start_addr;
  logic [31:0]   w_new_base;
  logic          w_start;
  logic [3:0]    w_cur;
  logic          w_cur_valid;
  logic [15:0]   w_list_next;
  logic          w_beat;
  logic          w_abort;

  assign w_n      = popcount16(REG_LIST);
  assign w_span   = LP_STEP * {27'd0, w_n};
  assign w_mode   = {P_BIT, U_BIT};
  assign w_start  = (r_state == IDLE) && START;

  always_comb begin
    w_start_addr = RN_DATA;
    case (w_mode)
      MODE_IA: w_start_addr = RN_DATA;
      MODE_IB: w_start_addr = RN_DATA + LP_STEP;
      MODE_DA: w_start_addr = RN_DATA - w_span + LP_STEP;
      MODE_DB: w_start_addr = RN_DATA - w_span;
      default: w_start_addr = RN_DATA;
    endcase
  end

  assign w_new_base = U_BIT ? (RN_DATA + w_span) : (RN_DATA - w_span);

  lowest_set_bit_encoder u_lsb (
    .i_vec   (r_list),
    .o_idx   (w_cur),
    .o_valid (w_cur_valid)
  );

  assign w_list_next = r_list & ~(16'd1 << w_cur);
  assign w_beat      = (r_state == XFER) && MEM_READY && w_cur_valid;

`ifdef LDM_STM_ABORT_EN
  logic r_aborted;
  assign w_abort = w_beat && MEM_ABORT;
  assign ABORTED = r_aborted;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_aborted <= 1'b0;
    end else if (w_start) begin
      r_aborted <= 1'b0;
    end else if (w_abort) begin
      r_aborted <= 1'b1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (START) w_state_nxt = (REG_LIST == 16'd0) ? FIN : XFER;
      XFER: begin
        if (w_abort) begin
          w_state_nxt = FIN;
        end else if (w_beat && (w_list_next == 16'd0)) begin
          w_state_nxt = WB;
        end
      end
      WB:      w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_list       <= 16'd0;
      r_addr       <= 32'd0;
      r_new_base   <= 32'd0;
      r_rn         <= 4'd0;
      r_load       <= 1'b0;
      r_w          <= 1'b0;
      r_rn_in_list <= 1'b0;
    end else if (w_start) begin
      r_list       <= REG_LIST;
      r_addr       <= w_start_addr;
      r_new_base   <= w_new_base;
      r_rn         <= ADDRS_RN;
      r_load       <= IS_LOAD;
      r_w          <= W_BIT;
      r_rn_in_list <= REG_LIST[ADDRS_RN];
    end else if (w_beat) begin
      r_list <= w_list_next;
      r_addr <= r_addr + LP_STEP;
    end
  end

  // A load that overwrote Rn keeps the loaded value; writeback is suppressed.
  always_comb begin
    MEM_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = 32'd0;
    MEM_WDATA = 32'd0;
    ADDRS_RM  = 4'd0;
    ADDRS_RD  = 4'd0;
    WRT_DATA  = 32'd0;
    WRT_ENA   = 1'b0;
    DONE      = 1'b0;
    BUSY      = (r_state != IDLE);
    case (r_state)
      XFER: begin
        MEM_REQ  = w_cur_valid;
        MEM_ADDR = r_addr;
        MEM_WE   = ~r_load;
        if (!r_load) begin
          ADDRS_RM  = w_cur;
          MEM_WDATA = RM_DATA;
        end else if (w_beat && !w_abort) begin
          WRT_ENA  = 1'b1;
          ADDRS_RD = w_cur;
          WRT_DATA = MEM_RDATA;
        end
      end
      WB: begin
        if (r_w && !(r_load && r_rn_in_list)) begin
          WRT_ENA  = 1'b1;
          ADDRS_RD = r_rn;
          WRT_DATA = r_new_base;
        end
      end
      FIN:     DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb/tb_ldm_stm_sequencer.sv - directed self-checking bench for ldm_stm_sequencer
module tb_ldm_stm_sequencer;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        IS_LOAD;
  logic        P_BIT;
  logic        U_BIT;
  logic        W_BIT;
  logic [3:0]  ADDRS_RN;
  logic [31:0] RN_DATA;
  logic [15:0] REG_LIST;
  logic [31:0] RM_DATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_READY;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  ADDRS_RM;
  logic [3:0]  ADDRS_RD;
  logic [31:0] WRT_DATA;
  logic        WRT_ENA;
  logic        BUSY;
  logic        DONE;
`ifdef LDM_STM_ABORT_EN
  logic        MEM_ABORT;
  logic        ABORTED;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_rd[$];
  logic [31:0] wr_dat[$];
  logic [31:0] bt_addr[$];
  logic [31:0] bt_we[$];
  logic [31:0] bt_wdata[$];
  logic [31:0] bt_rm[$];
  logic [31:0] stall_addr[$];
  int          req_cnt;
  logic        aborted_at_done;

  ldm_stm_sequencer #(.WORD_BYTES(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .IS_LOAD   (IS_LOAD),
    .P_BIT     (P_BIT),
    .U_BIT     (U_BIT),
    .W_BIT     (W_BIT),
    .ADDRS_RN  (ADDRS_RN),
    .RN_DATA   (RN_DATA),
    .REG_LIST  (REG_LIST),
    .RM_DATA   (RM_DATA),
    .MEM_RDATA (MEM_RDATA),
    .MEM_READY (MEM_READY),
`ifdef LDM_STM_ABORT_EN
    .MEM_ABORT (MEM_ABORT),
    .ABORTED   (ABORTED),
`endif
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .ADDRS_RM  (ADDRS_RM),
    .ADDRS_RD  (ADDRS_RD),
    .WRT_DATA  (WRT_DATA),
    .WRT_ENA   (WRT_ENA),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory and register file stand-ins with easily hand-computed data.
  assign MEM_RDATA = MEM_ADDR ^ 32'hA5A5_0000;
  assign RM_DATA   = 32'hCAFE_0000 | {28'd0, ADDRS_RM};

  always @(negedge CLK) begin
    if (WRT_ENA) begin
      wr_rd.push_back({28'd0, ADDRS_RD});
      wr_dat.push_back(WRT_DATA);
    end
    if (MEM_REQ) req_cnt++;
    if (MEM_REQ && MEM_READY) begin
      bt_addr.push_back(MEM_ADDR);
      bt_we.push_back({31'd0, MEM_WE});
      bt_wdata.push_back(MEM_WDATA);
      bt_rm.push_back({28'd0, ADDRS_RM});
    end
    if (MEM_REQ && !MEM_READY) stall_addr.push_back(MEM_ADDR);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_rd.delete(); wr_dat.delete();
    bt_addr.delete(); bt_we.delete(); bt_wdata.delete(); bt_rm.delete();
    stall_addr.delete();
    req_cnt = 0;
    aborted_at_done = 1'b0;
  endtask

  // Bit k of rdy_mask / abt_mask drives MEM_READY / MEM_ABORT in cycle k+1 after START.
  task automatic run_xfer(input logic ld, input logic p, input logic u, input logic w,
                          input logic [3:0] rn, input logic [31:0] base, input logic [15:0] list,
                          input logic [31:0] rdy_mask, input logic [31:0] abt_mask,
                          output int done_cyc);
    clear_logs();
    @(negedge CLK);
    START = 1'b1; IS_LOAD = ld; P_BIT = p; U_BIT = u; W_BIT = w;
    ADDRS_RN = rn; RN_DATA = base; REG_LIST = list;
    @(posedge CLK); #1;
    START = 1'b0;
    done_cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      MEM_READY = (c <= 32) ? rdy_mask[c-1] : 1'b1;
`ifdef LDM_STM_ABORT_EN
      MEM_ABORT = (c <= 32) ? abt_mask[c-1] : 1'b0;
`else
      if (abt_mask[c % 32] === 1'bx) MEM_READY = 1'b0;
`endif
      @(negedge CLK);
      if (DONE) begin
        done_cyc = c;
`ifdef LDM_STM_ABORT_EN
        aborted_at_done = ABORTED;
`endif
        break;
      end
      @(posedge CLK); #1;
    end
    MEM_READY = 1'b0;
`ifdef LDM_STM_ABORT_EN
    MEM_ABORT = 1'b0;
`endif
    @(posedge CLK); #1;
  endtask

  int dc;

  initial begin
    RST = 1'b0; START = 1'b0; IS_LOAD = 1'b0; P_BIT = 1'b0; U_BIT = 1'b0; W_BIT = 1'b0;
    ADDRS_RN = 4'd0; RN_DATA = 32'd0; REG_LIST = 16'd0; MEM_READY = 1'b0;
`ifdef LDM_STM_ABORT_EN
    MEM_ABORT = 1'b0;
`endif
    clear_logs();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_req", {31'd0, MEM_REQ}, 32'd0);
    chk("rst_wena", {31'd0, WRT_ENA}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_addr", MEM_ADDR, 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // LDM IA R13=0x1000 {R4-R7}!
    run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_1000, 16'h00F0, 32'hFFFF_FFFF, 32'd0, dc);
    chk("ia_done_cyc", dc, 32'd6);
    chk("ia_nwr", wr_rd.size(), 32'd5);
    chk("ia_nbeat", bt_addr.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("ia_addr", bt_addr[i], 32'h0000_1000 + 32'(4 * i));
      chk("ia_we", bt_we[i], 32'd0);
      chk("ia_rd", wr_rd[i], 32'(4 + i));
      chk("ia_data", wr_dat[i], 32'hA5A5_1000 + 32'(4 * i));
    end
    chk("ia_wb_rd", wr_rd[4], 32'd13);
    chk("ia_wb_data", wr_dat[4], 32'h0000_1010);
    chk("ia_idle", {31'd0, BUSY}, 32'd0);

    // STM DB R3=0x2000 {R0,R1,R15}!
    run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h0000_2000, 16'h8003, 32'hFFFF_FFFF, 32'd0, dc);
    chk("db_done_cyc", dc, 32'd5);
    chk("db_nbeat", bt_addr.size(), 32'd3);
    chk("db_addr0", bt_addr[0], 32'h0000_1FF4);
    chk("db_addr1", bt_addr[1], 32'h0000_1FF8);
    chk("db_addr2", bt_addr[2], 32'h0000_1FFC);
    chk("db_rm0", bt_rm[0], 32'd0);
    chk("db_rm1", bt_rm[1], 32'd1);
    chk("db_rm2", bt_rm[2], 32'd15);
    chk("db_wdata2", bt_wdata[2], 32'hCAFE_000F);
    chk("db_we", bt_we[1], 32'd1);
    chk("db_nwr", wr_rd.size(), 32'd1);
    chk("db_wb_rd", wr_rd[0], 32'd3);
    chk("db_wb_data", wr_dat[0], 32'h0000_1FF4);

    // LDM IB R2=0x3000 {R2,R4}! : loaded R2 wins over writeback
    run_xfer(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h0000_3000, 16'h0014, 32'hFFFF_FFFF, 32'd0, dc);
    chk("ib_done_cyc", dc, 32'd4);
    chk("ib_nwr", wr_rd.size(), 32'd2);
    chk("ib_rd0", wr_rd[0], 32'd2);
    chk("ib_data0", wr_dat[0], 32'hA5A5_3004);
    chk("ib_rd1", wr_rd[1], 32'd4);
    chk("ib_data1", wr_dat[1], 32'hA5A5_3008);

    // LDM IA R1=0x4000 {R0-R2}, no writeback, 3-cycle stall on beat 2
    run_xfer(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 32'h0000_4000, 16'h0007, 32'hFFFF_FFF1, 32'd0, dc);
    chk("st_done_cyc", dc, 32'd8);
    chk("st_nstall", stall_addr.size(), 32'd3);
    for (int i = 0; i < 3; i++) chk("st_hold_addr", stall_addr[i], 32'h0000_4004);
    chk("st_nwr", wr_rd.size(), 32'd3);
    chk("st_addr2", bt_addr[2], 32'h0000_4008);
    chk("st_data1", wr_dat[1], 32'hA5A5_4004);

    // DA with address wrap: R0=0x4 {R1,R2,R3} -> 0xFFFFFFFC.., base 0xFFFFFFF8
    run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0000_0004, 16'h000E, 32'hFFFF_FFFF, 32'd0, dc);
    chk("da_addr0", bt_addr[0], 32'hFFFF_FFFC);
    chk("da_addr2", bt_addr[2], 32'h0000_0004);
    chk("da_wb_data", wr_dat[0], 32'hFFFF_FFF8);

    // Empty list
    run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 32'h0000_5000, 16'h0000, 32'hFFFF_FFFF, 32'd0, dc);
    chk("empty_done_cyc", dc, 32'd1);
    chk("empty_req", req_cnt, 32'd0);
    chk("empty_nwr", wr_rd.size(), 32'd0);

`ifdef LDM_STM_ABORT_EN
    // Abort on beat 2 of 4
    run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 32'h0000_5000, 16'h000F, 32'hFFFF_FFFF, 32'h0000_0002, dc);
    chk("ab_done_cyc", dc, 32'd3);
    chk("ab_aborted", {31'd0, aborted_at_done}, 32'd1);
    chk("ab_nwr", wr_rd.size(), 32'd1);
    chk("ab_rd0", wr_rd[0], 32'd0);
    chk("ab_data0", wr_dat[0], 32'hA5A5_5000);
    run_xfer(1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 32'h0000_6000, 16'h0001, 32'hFFFF_FFFF, 32'd0, dc);
    chk("ab_cleared", {31'd0, ABORTED}, 32'd0);
`endif

    // Reset asserted mid-transfer while beat 2 is stalled
    clear_logs();
    @(negedge CLK);
    START = 1'b1; IS_LOAD = 1'b1; P_BIT = 1'b0; U_BIT = 1'b1; W_BIT = 1'b1;
    ADDRS_RN = 4'd9; RN_DATA = 32'h0000_7000; REG_LIST = 16'h00FF;
    @(posedge CLK); #1;
    START = 1'b0; MEM_READY = 1'b1;
    @(posedge CLK); #1;
    MEM_READY = 1'b0;
    @(posedge CLK); #1;
    chk("mid_busy", {31'd0, BUSY}, 32'd1);
    RST = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, MEM_REQ}, 32'd0);
    chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("mid_rst_addr", MEM_ADDR, 32'd0);
    chk("mid_rst_wena", {31'd0, WRT_ENA}, 32'd0);
    MEM_READY = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b1;
    MEM_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("mid_nwr", wr_rd.size(), 32'd1);
    chk("mid_after_busy", {31'd0, BUSY}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
